// File: rtl/matrix_pkg.sv
// Shared matrix definitions: dimension limits, request modes, scanner FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package matrix_pkg;

    localparam int DIM_W     = 4;
    localparam int MAX_DIM   = 5;
    localparam int MAX_STORE = 8;

    typedef enum logic [1:0] {
        MODE_EXACT     = 2'd0,
        MODE_TRANSPOSE = 2'd1,
        MODE_MUL_RHS   = 2'd2,
        MODE_ANY       = 2'd3
    } req_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_DONE = 2'd2
    } scan_state_e;

endpackage

// File: rtl/lsb_prio_enc.sv
// Lowest-set-bit priority encoder: one-hot, binary index and any flag of a mask.
// Latency: combinational.
// Backpressure: none.
// Ports: req (mask in), onehot (lowest set bit), idx (its position), any (mask non-zero).
module lsb_prio_enc #(
    parameter int W     = 8,
    parameter int IDX_W = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]     req,
    output logic [W-1:0]     onehot,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Two's-complement trick isolates the lowest set bit.
    assign onehot = req & (~req + W'(1));
    assign any    = |req;

    // Scan from the top so the lowest set bit is the last writer.
    always_comb begin
        idx = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/dim_match_scanner.sv
// Snapshots storage dims on start and streams matching slot codes in ascending order.
// Latency: first hit (or done when empty) one cycle after start; one hit per cycle after.
// Backpressure: hit outputs hold while hit_valid && !hit_ready; no bubble between hits.
// Ports: clk/rst (sync, active-high); start/abort control; req_mode/req_m/req_n request;
//   stored_m/stored_n/slot_valid storage view; hit_* valid/ready stream; match_mask,
//   match_count snapshot results; busy; done pulse.
// Optional: DIM_SCAN_EXCLUDE_EN adds excl_valid/excl_slot to drop one slot from the scan.
module dim_match_scanner
    import matrix_pkg::*;
#(
    parameter int MAX_DIM   = matrix_pkg::MAX_DIM,
    parameter int MAX_STORE = matrix_pkg::MAX_STORE,
    parameter int DIM_W     = matrix_pkg::DIM_W,
    parameter int SLOT_W    = (MAX_STORE > 1) ? $clog2(MAX_STORE) : 1,
    parameter int CNT_W     = $clog2(MAX_STORE + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       abort,
    input  logic [1:0]                 req_mode,
    input  logic [DIM_W-1:0]           req_m,
    input  logic [DIM_W-1:0]           req_n,
    input  logic [DIM_W*MAX_STORE-1:0] stored_m,
    input  logic [DIM_W*MAX_STORE-1:0] stored_n,
    input  logic [MAX_STORE-1:0]       slot_valid,
`ifdef DIM_SCAN_EXCLUDE_EN
    input  logic                       excl_valid,
    input  logic [SLOT_W-1:0]          excl_slot,
`endif
    output logic                       busy,
    output logic                       hit_valid,
    input  logic                       hit_ready,
    output logic [SLOT_W-1:0]          hit_slot,
    output logic [DIM_W-1:0]           hit_m,
    output logic [DIM_W-1:0]           hit_n,
    output logic [CNT_W-1:0]           hit_idx,
    output logic                       hit_last,
    output logic [MAX_STORE-1:0]       match_mask,
    output logic [CNT_W-1:0]           match_count,
    output logic                       done
);

    scan_state_e            state_q, state_d;
    logic [MAX_STORE-1:0]   mask_q, pend_q;
    logic [CNT_W-1:0]       count_q, idx_q;
    logic [DIM_W-1:0]       snap_m_q [MAX_STORE];
    logic [DIM_W-1:0]       snap_n_q [MAX_STORE];

    logic [MAX_STORE-1:0]   new_mask;
    logic [CNT_W-1:0]       new_count;
    logic [MAX_STORE-1:0]   pend_onehot;
    logic [SLOT_W-1:0]      pend_idx;
    logic                   pend_any;
    logic                   is_last;
    logic                   dims_legal;

    // ---------------- match compare (live inputs, captured on start) ----------------
    assign dims_legal = (req_m != '0) && (req_n != '0) &&
                        (int'(req_m) <= MAX_DIM) && (int'(req_n) <= MAX_DIM);

    always_comb begin
        new_mask = '0;
        for (int i = 0; i < MAX_STORE; i++) begin
            logic [DIM_W-1:0] sm, sn;
            sm = stored_m[i*DIM_W +: DIM_W];
            sn = stored_n[i*DIM_W +: DIM_W];
            case (req_mode_e'(req_mode))
                MODE_EXACT:     new_mask[i] = dims_legal && (sm == req_m) && (sn == req_n);
                MODE_TRANSPOSE: new_mask[i] = dims_legal && (sm == req_n) && (sn == req_m);
                MODE_MUL_RHS:   new_mask[i] = dims_legal && (sm == req_n);
                default:        new_mask[i] = 1'b1;
            endcase
        end
        new_mask = new_mask & slot_valid;
`ifdef DIM_SCAN_EXCLUDE_EN
        // Lets a caller pick a second operand distinct from one already chosen.
        if (excl_valid && (int'(excl_slot) < MAX_STORE)) begin
            new_mask[excl_slot] = 1'b0;
        end
`endif
    end

    always_comb begin
        new_count = '0;
        for (int i = 0; i < MAX_STORE; i++) begin
            new_count = new_count + CNT_W'(new_mask[i]);
        end
    end

    // ---------------- hit selection from the pending mask ----------------
    lsb_prio_enc #(
        .W     (MAX_STORE),
        .IDX_W (SLOT_W)
    ) u_prio (
        .req    (pend_q),
        .onehot (pend_onehot),
        .idx    (pend_idx),
        .any    (pend_any)
    );

    // Current hit is last when nothing remains once it is taken.
    assign is_last = pend_any && ((pend_q & ~pend_onehot) == '0);

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        busy      = 1'b0;
        hit_valid = 1'b0;
        done      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // abort is irrelevant here: start always wins in IDLE.
                if (start) begin
                    state_d = (new_mask != '0) ? ST_EMIT : ST_DONE;
                end
            end
            ST_EMIT: begin
                busy      = 1'b1;
                hit_valid = 1'b1;
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (hit_ready && is_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- snapshot and progress registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q  <= '0;
            pend_q  <= '0;
            count_q <= '0;
            idx_q   <= '0;
            for (int i = 0; i < MAX_STORE; i++) begin
                snap_m_q[i] <= '0;
                snap_n_q[i] <= '0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        mask_q  <= new_mask;
                        pend_q  <= new_mask;
                        count_q <= new_count;
                        idx_q   <= '0;
                        for (int i = 0; i < MAX_STORE; i++) begin
                            snap_m_q[i] <= stored_m[i*DIM_W +: DIM_W];
                            snap_n_q[i] <= stored_n[i*DIM_W +: DIM_W];
                        end
                    end
                end
                ST_EMIT: begin
                    if (abort) begin
                        pend_q <= '0;
                        idx_q  <= '0;
                    end else if (hit_ready) begin
                        pend_q <= pend_q & ~pend_onehot;
                        idx_q  <= idx_q + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    idx_q <= '0;
                end
                default: ;
            endcase
        end
    end

    assign hit_slot    = hit_valid ? pend_idx : '0;
    assign hit_m       = hit_valid ? snap_m_q[pend_idx] : '0;
    assign hit_n       = hit_valid ? snap_n_q[pend_idx] : '0;
    assign hit_idx     = idx_q;
    assign hit_last    = hit_valid && is_last;
    assign match_mask  = mask_q;
    assign match_count = count_q;

endmodule

// File: tb/tb_dim_match_scanner.sv
// Directed bench for dim_match_scanner: hit order, backpressure, empty scans, modes,
// abort, ignored start, reset mid-scan and (when enabled) slot exclusion.
// Latency/backpressure: n/a.
module tb_dim_match_scanner;

    localparam int DIM_W     = 4;
    localparam int MAX_STORE = 8;
    localparam int SLOT_W    = 3;
    localparam int CNT_W     = 4;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       start, abort, hit_ready;
    logic [1:0]                 req_mode;
    logic [DIM_W-1:0]           req_m, req_n;
    logic [DIM_W*MAX_STORE-1:0] stored_m, stored_n;
    logic [MAX_STORE-1:0]       slot_valid;
    logic                       busy, hit_valid, hit_last, done;
    logic [SLOT_W-1:0]          hit_slot;
    logic [DIM_W-1:0]           hit_m, hit_n;
    logic [CNT_W-1:0]           hit_idx, match_count;
    logic [MAX_STORE-1:0]       match_mask;
`ifdef DIM_SCAN_EXCLUDE_EN
    logic                       excl_valid;
    logic [SLOT_W-1:0]          excl_slot;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dim_match_scanner dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .req_mode    (req_mode),
        .req_m       (req_m),
        .req_n       (req_n),
        .stored_m    (stored_m),
        .stored_n    (stored_n),
        .slot_valid  (slot_valid),
`ifdef DIM_SCAN_EXCLUDE_EN
        .excl_valid  (excl_valid),
        .excl_slot   (excl_slot),
`endif
        .busy        (busy),
        .hit_valid   (hit_valid),
        .hit_ready   (hit_ready),
        .hit_slot    (hit_slot),
        .hit_m       (hit_m),
        .hit_n       (hit_n),
        .hit_idx     (hit_idx),
        .hit_last    (hit_last),
        .match_mask  (match_mask),
        .match_count (match_count),
        .done        (done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Hit {valid, slot, idx, last} in one go.
    task automatic chk_hit(input string tag, input logic v, input int slot, input int idx,
                           input logic last);
        chk({tag, "_valid"}, 32'(hit_valid), 32'(v));
        chk({tag, "_slot"},  32'(hit_slot),  32'(slot));
        chk({tag, "_idx"},   32'(hit_idx),   32'(idx));
        chk({tag, "_last"},  32'(hit_last),  32'(last));
    endtask

    task automatic set_slot(input int i, input int m, input int n);
        stored_m[i*DIM_W +: DIM_W] = DIM_W'(m);
        stored_n[i*DIM_W +: DIM_W] = DIM_W'(n);
    endtask

    // Base storage: slots0..3 = 2x3,3x2,2x3,2x3; slot5 holds 2x3 but is not occupied.
    task automatic load_storage();
        stored_m = '0;
        stored_n = '0;
        set_slot(0, 2, 3);
        set_slot(1, 3, 2);
        set_slot(2, 2, 3);
        set_slot(3, 2, 3);
        set_slot(5, 2, 3);
        slot_valid = 8'b0000_1111;
    endtask

    task automatic kick(input int mode, input int m, input int n);
        start    = 1'b1;
        req_mode = 2'(mode);
        req_m    = DIM_W'(m);
        req_n    = DIM_W'(n);
        step();
        start    = 1'b0;
    endtask

    // Runs a scan out with hit_ready=1, counting handshakes; bounded wait for done.
    task automatic run_to_done(input string tag, input int exp_hits);
        int  hits = 0;
        logic seen = 1'b0;
        hit_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (hit_valid) hits++;
            step();
        end
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        chk({tag, "_hits"}, 32'(hits), 32'(exp_hits));
        step();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; hit_ready = 1'b1;
        req_mode = 2'd0; req_m = '0; req_n = '0;
`ifdef DIM_SCAN_EXCLUDE_EN
        excl_valid = 1'b0; excl_slot = '0;
`endif
        load_storage();
        step();
        step();
        rst = 1'b0;

        // Reset state
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_done",  32'(done), 32'd0);
        chk("rst_mask",  32'(match_mask), 32'd0);
        chk("rst_count", 32'(match_count), 32'd0);
        chk_hit("rst", 1'b0, 0, 0, 1'b0);

        // EXACT 2x3, ready high; storage is scrambled after the start edge.
        kick(0, 2, 3);
        slot_valid = '0;
        set_slot(0, 5, 5);
        set_slot(3, 1, 1);
        chk("t1_mask",  32'(match_mask), 32'h0D);
        chk("t1_count", 32'(match_count), 32'd3);
        chk("t1_busy",  32'(busy), 32'd1);
        chk_hit("t1_h0", 1'b1, 0, 0, 1'b0);
        chk("t1_h0_m", 32'(hit_m), 32'd2);
        chk("t1_h0_n", 32'(hit_n), 32'd3);
        step();
        chk_hit("t1_h1", 1'b1, 2, 1, 1'b0);
        step();
        chk_hit("t1_h2", 1'b1, 3, 2, 1'b1);
        chk("t1_h2_m", 32'(hit_m), 32'd2);
        chk("t1_h2_n", 32'(hit_n), 32'd3);
        step();
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_done_hv", 32'(hit_valid), 32'd0);
        chk("t1_done_busy", 32'(busy), 32'd1);
        step();
        chk("t1_idle_done", 32'(done), 32'd0);
        chk("t1_idle_busy", 32'(busy), 32'd0);
        chk("t1_hold_mask", 32'(match_mask), 32'h0D);
        load_storage();

        // Same scan with ready low for three cycles at the first hit.
        hit_ready = 1'b0;
        kick(0, 2, 3);
        for (int c = 0; c < 3; c++) begin
            chk_hit("t2_stall", 1'b1, 0, 0, 1'b0);
            chk("t2_stall_m", 32'(hit_m), 32'd2);
            step();
        end
        hit_ready = 1'b1;
        chk_hit("t2_h0", 1'b1, 0, 0, 1'b0);
        step();
        chk_hit("t2_h1", 1'b1, 2, 1, 1'b0);
        step();
        chk_hit("t2_h2", 1'b1, 3, 2, 1'b1);
        step();
        chk("t2_done", 32'(done), 32'd1);
        step();

        // EXACT 4x4: no match, done one cycle after start.
        kick(0, 4, 4);
        chk("t3_hv",    32'(hit_valid), 32'd0);
        chk("t3_done",  32'(done), 32'd1);
        chk("t3_count", 32'(match_count), 32'd0);
        chk("t3_mask",  32'(match_mask), 32'd0);
        step();
        chk("t3_busy",  32'(busy), 32'd0);

        // Out-of-range request dims give an empty mask.
        kick(0, 6, 3);
        chk("t3b_mask", 32'(match_mask), 32'd0);
        chk("t3b_done", 32'(done), 32'd1);
        step();
        kick(1, 0, 2);
        chk("t3c_mask", 32'(match_mask), 32'd0);
        step();

        // TRANSPOSE 3x2 -> slots 0,2,3
        kick(1, 3, 2);
        chk("t4_mask", 32'(match_mask), 32'h0D);
        run_to_done("t4", 3);

        // MUL_RHS 4x2 -> slots with m=2; MUL_RHS 4x3 -> slot1 only
        kick(2, 4, 2);
        chk("t5_mask", 32'(match_mask), 32'h0D);
        run_to_done("t5", 3);
        kick(2, 4, 3);
        chk("t5b_mask", 32'(match_mask), 32'h02);
        chk_hit("t5b_h0", 1'b1, 1, 0, 1'b1);
        run_to_done("t5b", 1);

        // ANY_VALID with zero dims: every occupied slot, not slot5.
        kick(3, 0, 0);
        chk("t6_mask",  32'(match_mask), 32'h0F);
        chk("t6_count", 32'(match_count), 32'd4);
        run_to_done("t6", 4);

        // Abort after the first handshake.
        kick(0, 2, 3);
        step();
        chk_hit("t7_h1", 1'b1, 2, 1, 1'b0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t7_busy",  32'(busy), 32'd0);
        chk("t7_hv",    32'(hit_valid), 32'd0);
        chk("t7_done",  32'(done), 32'd0);
        chk("t7_mask",  32'(match_mask), 32'h0D);
        chk("t7_count", 32'(match_count), 32'd3);
        step();
        chk("t7_done2", 32'(done), 32'd0);

        // Start during EMIT is ignored.
        hit_ready = 1'b0;
        kick(0, 2, 3);
        kick(3, 0, 0);
        chk_hit("t8_h0", 1'b1, 0, 0, 1'b0);
        chk("t8_mask", 32'(match_mask), 32'h0D);
        run_to_done("t8", 3);

        // start+abort in IDLE: start wins. Then reset mid-EMIT.
        hit_ready = 1'b0;
        abort = 1'b1;
        kick(3, 0, 0);
        abort = 1'b0;
        chk("t9_hv",   32'(hit_valid), 32'd1);
        chk("t9_mask", 32'(match_mask), 32'h0F);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t9_rst_busy",  32'(busy), 32'd0);
        chk("t9_rst_done",  32'(done), 32'd0);
        chk("t9_rst_mask",  32'(match_mask), 32'd0);
        chk("t9_rst_count", 32'(match_count), 32'd0);
        chk_hit("t9_rst", 1'b0, 0, 0, 1'b0);
        chk("t9_rst_m", 32'(hit_m), 32'd0);

`ifdef DIM_SCAN_EXCLUDE_EN
        // Exclude slot 2 from EXACT 2x3 -> hits 0,3.
        hit_ready  = 1'b1;
        excl_valid = 1'b1;
        excl_slot  = 3'd2;
        kick(0, 2, 3);
        excl_valid = 1'b0;
        chk("tx_mask",  32'(match_mask), 32'h09);
        chk("tx_count", 32'(match_count), 32'd2);
        chk_hit("tx_h0", 1'b1, 0, 0, 1'b0);
        step();
        chk_hit("tx_h1", 1'b1, 3, 1, 1'b1);
        step();
        chk("tx_done", 32'(done), 32'd1);
        step();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
